btn_conditioner: RTL
====================

# btn_conditioner

Five-channel push-button conditioner for the board's centre, top, bottom, left and right buttons. Each raw button input is synchronised into `clk`, debounced by a per-channel state machine, and turned into a debounced level plus a single-cycle press pulse. It sits directly upstream of the game's main state machine, so each physical press advances that state machine exactly once regardless of contact bounce or hold time.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000 (10 ms at 100 MHz): consecutive stable synchronised samples required to accept a level change; legal range ≥ 2.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  5  raw buttons, active-high, asynchronous: [0] centre, [1] top, [2] bottom, [3] left, [4] right.
- `btn_level`  out  5  debounced level per button, same bit order.
- `btn_pulse`  out  5  one-cycle pulse on each accepted press (debounced rising edge), same bit order.
- `any_pulse`  out  1  OR of `btn_pulse`, registered in the same cycle as `btn_pulse`.

## Operation
- Per channel:
  - Two-flop synchroniser produces `s`.
  - A 4-state FSM uses `cnt`, width clog2(`DEBOUNCE_CYCLES`).
- States and transitions (evaluated at each `clk` edge):
  - RELEASED: `s`=1 moves to PRESS_PEND with `cnt`=0.
  - PRESS_PEND:
    - `s`=0 returns to RELEASED and clears `cnt`.
    - `s`=1 with `cnt`<N−1 increments `cnt`.
    - `s`=1 with `cnt`==N−1 moves to PRESSED, sets `btn_level`=1, and pulses `btn_pulse` for one cycle.
  - PRESSED: `s`=0 moves to RELEASE_PEND with `cnt`=0.
  - RELEASE_PEND:
    - `s`=1 returns to PRESSED and clears `cnt`.
    - `s`=0 with `cnt`<N−1 increments `cnt`.
    - `s`=0 with `cnt`==N−1 moves to RELEASED and sets `btn_level`=0. A release produces no pulse.
- Bounce handling: any sample that disagrees with the pending level aborts the pending change. The counter never carries across an abort.
- Holding a button produces exactly one pulse. Re-arming requires an accepted release first.
- Channels are fully independent. Simultaneous presses yield simultaneous pulses, and priority is the consumer's concern.
- `btn_pulse` and `any_pulse` are registered outputs with no combinational path from `btn_raw`.

## Timing
- Reset (asynchronous, any time):
  - All synchroniser flops, `cnt`, `btn_level`, `btn_pulse` and `any_pulse` go to 0.
  - All FSMs go to RELEASED.
  - Reset mid-PRESS_PEND discards the pending press, and no pulse follows deassertion unless the button stays high for a full new debounce period.
- Button held through reset deassertion: treated as a fresh press. The pulse arrives N+3 cycles after the first sampling edge.
- Press latency, counting edge 0 as the first edge sampling `btn_raw`=1 with the raw input stable:
  - Synchroniser output `s`=1 after edge 1.
  - PRESS_PEND after edge 2.
  - PRESSED after edge N+2.
  - `btn_pulse` is high for exactly the cycle between edges N+2 and N+3.
- Release latency is symmetric: `btn_level` falls after edge N+2.
- Minimum accepted pulse width at the raw pin is N+1 cycles. Shorter highs never reach PRESSED.

## Structure
- Shared package `btn_pkg` holds:
  - The channel state enum (RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND).
  - Index constants BTN_CENTER=0, BTN_TOP=1, BTN_BOTTOM=2, BTN_LEFT=3, BTN_RIGHT=4.
  - NUM_BTN=5.
- Sub-module `btn_debounce_ch` contains the synchroniser, FSM and counter for one channel. It is parameterised by `DEBOUNCE_CYCLES` and instantiated NUM_BTN times via generate.
- The top level adds only the `any_pulse` OR register.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Clean press: `btn_raw`[0] rises before edge 0 and is held 20 cycles → `btn_pulse`=5'b00001 only between edges 6 and 7, `any_pulse`=1 in the same cycle, `btn_level`[0]=1 from edge 6 on, and no further pulses.
- Glitch rejection: `btn_raw`[1] high for 3 cycles then low → `btn_pulse` and `btn_level` stay 0 throughout.
- Bounce: `btn_raw`[3] pattern 1,1,0,1,1,1,1,1… → the pulse arrives 4+3 cycles after the final 0→1 transition, and exactly one pulse is produced.
- Simultaneous: `btn_raw`[0] and `btn_raw`[4] rise in the same cycle → `btn_pulse`=5'b10001 for one cycle and `any_pulse`=1.
- Release and re-press: after an accepted press, low 10 cycles → `btn_level`[2] falls with no pulse. A second press then yields a second single pulse.
- Reset mid-pend: assert `reset_n`=0 while channel 0 is in PRESS_PEND with `cnt`=2 → all outputs are 0 immediately. Keep the button held after deassertion → the pulse arrives 7 cycles after the first post-reset edge.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and constants for the five-button conditioner.
// Channel state encoding and board button indices.
package btn_pkg;

  localparam int NUM_BTN    = 5;
  localparam int BTN_CENTER = 0;
  localparam int BTN_TOP    = 1;
  localparam int BTN_BOTTOM = 2;
  localparam int BTN_LEFT   = 3;
  localparam int BTN_RIGHT  = 4;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce FSM and
// stability counter, producing a level and a single press pulse.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic pulse_next
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          s;

  assign s = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (s) state_d = PRESS_PEND;
      end
      PRESS_PEND: begin
        if (!s) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) state_d = RELEASE_PEND;
      end
      RELEASE_PEND: begin
        // any high sample abandons the pending release
        if (s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= RELEASED;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign level = (state_q == PRESSED) ||
                 (state_q == RELEASE_PEND);
  assign pulse      = pulse_q;
  assign pulse_next = pulse_d;

endmodule

// File: rtl/btn_conditioner.sv
// Five-channel push-button conditioner: debounced levels, press
// pulses and a combined any-press pulse, all registered.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [4:0]   btn_raw,
  output logic [4:0]   btn_level,
  output logic [4:0]   btn_pulse,
  output logic         any_pulse
);

  logic [NUM_BTN-1:0] pulse_nx;
  logic               any_pulse_q, any_pulse_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .raw        (btn_raw[i]),
      .level      (btn_level[i]),
      .pulse      (btn_pulse[i]),
      .pulse_next (pulse_nx[i])
    );
  end

  // OR the next-state pulses so any_pulse lines up with btn_pulse
  always_comb begin
    any_pulse_d = |pulse_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) any_pulse_q <= 1'b0;
    else          any_pulse_q <= any_pulse_d;
  end

  assign any_pulse = any_pulse_q;

endmodule
